mult_share_ctrl: RTL
====================

// Module: mult_share_ctrl
// PURPOSE
//  Time-shares one combinational WxW array multiplier (partial-product tree + final adder)
//  between N requesters, each with a valid/ready request and response channel.
//  Arbitration is round-robin. The block registers the winner's operands and drives them to the
//  multiplier. It waits SETTLE cycles (multicycle path), then captures the 2W-bit product and
//  returns it to the same requester.
//  Sits between the requester blocks and the multiplier instance; the multiplier stays purely
//  combinational.
// PARAMETERS
//  W       4   operand width in bits; product width is 2*W
//  N       2   number of requesters, 2..8
//  SETTLE  1   cycles mul_o is allowed to settle after operands change, 1..15
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  req_valid  in   N      requester i has operands pending
//  req_x      in   N*W    operand x, slice i = req_x[i*W +: W]
//  req_y      in   N*W    operand y, same slicing
//  req_ready  out  N      one-hot or zero; grant/accept for requester i
//  rsp_valid  out  N      one-hot or zero; product ready for requester i
//  rsp_ready  in   N      requester i accepts its product
//  rsp_o      out  2*W    product; shared bus, meaningful only where rsp_valid is set
//  mul_x      out  W      registered operand to multiplier
//  mul_y      out  W      registered operand to multiplier
//  mul_o      in   2*W    multiplier result, combinational from mul_x/mul_y
//  busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0, all outputs 0, including mul_x,
//  mul_y, rsp_o and the owner register.
//  FSM:
//   IDLE: if any req_valid, pick first set bit at or after rr_ptr (wrapping N-1 -> 0).
//         Assert req_ready for that bit only, combinationally, this cycle.
//         Handshake fires in this cycle: latch x/y into mul_x/mul_y, owner <= i,
//         cnt <= SETTLE-1, go WAIT. No req_valid: stay IDLE, req_ready=0.
//   WAIT: hold mul_x/mul_y stable. Decrement cnt. At cnt==0, rsp_o <= mul_o, go RESP.
//   RESP: rsp_valid[owner]=1 and rsp_o held stable until rsp_ready[owner].
//         On that cycle: rr_ptr <= (owner+1) mod N, go IDLE.
//  Latency: request accept at cycle t -> rsp_valid at cycle t+SETTLE+1, when the requester is
//  ready at once. Throughput is one product per SETTLE+2 cycles.
//  Only one operation is in flight. req_ready stays 0 in WAIT and RESP.
//  Arithmetic: unsigned, full 2W-bit product, no truncation or saturation.
//  rsp_ready on a non-owner line is ignored. A requester dropping req_valid before grant is legal
//  and has no effect. Once granted, the operation completes regardless of later req_valid.
//  Simultaneous requests: the rr_ptr winner is served; the others wait. Starvation-free,
//  max wait N-1 operations.
//  rr_ptr wraps N-1 -> 0. An owner==N-1 completion sets rr_ptr=0.
//  Back-pressure: rsp_ready low holds RESP indefinitely. Must not re-arbitrate or overwrite
//  rsp_o.
//  Reset mid-operation (WAIT/RESP) aborts immediately. No rsp_valid is produced afterwards for
//  the aborted request.
//  X-safety: mul_o is sampled only in the WAIT->RESP transition.
// STRUCTURE
//  Shared package mult_pkg:
//   - state enum {IDLE, WAIT, RESP}
//   - function next_rr(ptr, vec, N) returning winner index and a found flag
//   - localparam PW = 2*W
//  One natural sub-module: rr_arbiter (req vector + ptr -> one-hot grant, index).
//  Counter, operand/result registers and FSM live in mult_share_ctrl.
//  The multiplier is instantiated beside this block, not inside it.
// TESTING
//  Bench instantiates the block with the real 4x4 multiplier, W=4, N=2, SETTLE=1.
//  1. Reset then idle: req_valid=0 for 10 cycles
//     -> busy=0, req_ready=0, rsp_valid=0, mul_x=mul_y=0.
//  2. Single request: req0 x=15, y=15
//     -> req_ready[0] same cycle, rsp_valid[0] 2 cycles later, rsp_o=8'hE1 (225).
//  3. Contention: both valid, req0 (3,5) and req1 (7,9), rsp_ready tied 1
//     -> grants 0 then 1, rsp_o=15 then 63, rr_ptr returns to 0.
//  4. Back-pressure: req1 (2,6), rsp_ready[1]=0 for 5 cycles
//     -> rsp_valid[1] held and rsp_o=12 stable, req_ready=0, no new grant until accepted.
//  5. Reset mid-WAIT (SETTLE=4 build): assert rst_n=0 two cycles after grant
//     -> all outputs 0 asynchronously, no response after release.
//  6. Exhaustive: all 256 (x,y) pairs alternating requesters
//     -> every rsp_o == x*y; fairness counts differ by at most 1.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the time-shared multiplier controller.
package mult_pkg;

    localparam int unsigned MAX_N  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DEF_W  = 4;
    localparam int unsigned DEF_PW = 2 * DEF_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of vec at or after ptr, wrapping n-1 -> 0; ptr must be < n.
    function automatic rr_pick_t next_rr(input logic [IDX_W-1:0] ptr,
                                         input logic [MAX_N-1:0] vec,
                                         input int unsigned      n);
        rr_pick_t    pick;
        int unsigned k;
        pick = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            k = 32'(ptr) + i;
            if (k >= n) begin
                k = k - n;
            end
            if ((i < n) && !pick.found && vec[IDX_W'(k)]) begin
                pick.found = 1'b1;
                pick.idx   = IDX_W'(k);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: request vector plus priority pointer -> one-hot grant and index.
module rr_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    rr_pick_t w_pick;

    always_comb begin
        w_pick  = next_rr(i_ptr, MAX_N'(i_req), N);
        o_found = w_pick.found;
        o_idx   = w_pick.idx;
        o_gnt   = w_pick.found ? (N'(1) << w_pick.idx) : '0;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one external combinational multiplier between N requesters, one
// operation in flight, round-robin arbitration, SETTLE-cycle multicycle wait.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned W      = 4,
    parameter int unsigned N      = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_x,
    input  logic [N*W-1:0]   req_y,
    output logic [N-1:0]     req_ready,
    output logic [N-1:0]     rsp_valid,
    input  logic [N-1:0]     rsp_ready,
    output logic [2*W-1:0]   rsp_o,
    output logic [W-1:0]     mul_x,
    output logic [W-1:0]     mul_y,
    input  logic [2*W-1:0]   mul_o,
    output logic             busy
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_mul_x;
    logic [W-1:0]     r_mul_y;
    logic [PW-1:0]    r_rsp;

    logic [N-1:0]     w_gnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic [IW-1:0]    w_win;
    logic             w_accept;
    logic             w_settled;
    logic             w_rsp_fire;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (IDX_W'(r_rr_ptr)),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    assign w_win      = IW'(w_idx);
    assign w_accept   = (r_state == IDLE) && w_found;
    assign w_settled  = (r_state == WAIT) && (r_cnt == '0);
    assign w_rsp_fire = (r_state == RESP) && rsp_ready[r_owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_found)    w_next_state = WAIT;
            WAIT:    if (w_settled)  w_next_state = RESP;
            RESP:    if (w_rsp_fire) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grant is combinational so the accept handshake completes in the IDLE cycle.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = 1'b0;
        case (r_state)
            IDLE: req_ready = w_gnt;
            WAIT: busy      = 1'b1;
            RESP: begin
                busy      = 1'b1;
                rsp_valid = N'(1) << r_owner;
            end
            default: ;
        endcase
    end

    // Operand, counter, owner and product registers; mul_o is sampled only when settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_x  <= '0;
            r_mul_y  <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_rsp    <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_mul_x <= req_x[w_win*W +: W];
                r_mul_y <= req_y[w_win*W +: W];
                r_owner <= w_win;
                r_cnt   <= CNT_W'(SETTLE - 1);
            end
            if (r_state == WAIT) begin
                if (r_cnt == '0) begin
                    r_rsp <= mul_o;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            if (w_rsp_fire) begin
                r_rr_ptr <= (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);
            end
        end
    end

    assign mul_x = r_mul_x;
    assign mul_y = r_mul_y;
    assign rsp_o = r_rsp;

endmodule
